// File: rtl/inst_fetch_bridge_pkg.sv
// Shared definitions for the Sirius instruction fetch bridge.
// Holds the default bus widths used by the CPU top level and the fetch FSM
// state encoding, so the bridge, its buffer and any checker agree on them.
package inst_fetch_bridge_pkg;

  localparam int InstAddrBus = 32;  // default instruction address width
  localparam int InstBus     = 32;  // default instruction width

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_bridge_fetch_buf.sv
// fetch_buf: circular FIFO of {tag, data} entries for prefetched instructions.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   clear                drop every entry (wins over push/pop in the same cycle)
//   push, push_tag/data  append one entry at the tail
//   pop                  remove the head entry (caller never pops when empty)
//   head_tag, head_data  oldest entry, valid while empty=0
//   count, empty         occupancy
// Push and pop in the same cycle are allowed when full: the write lands in the
// slot the head is leaving at that edge.
module fetch_buf #(
  parameter int TAG_W  = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [TAG_W-1:0]  push_tag,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [TAG_W-1:0]  head_tag,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      tag_mem[wr_ptr]  <= push_tag;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_tag  = tag_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign empty     = (count == '0);

endmodule

// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: Sirius core fetch port to instruction ROM bridge.
// Prefetches sequential instructions into a tagged FIFO and serves core
// requests from it; any request that does not match the sequential stream
// flushes the buffer and the in-flight ROM reads and restarts at the new PC.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_i, addr_i             core fetch request and address (low bits ignored)
//   inst_o, inst_valid_o      instruction and acknowledge (inst_o=0 when no ack)
//   rom_ce_o, rom_addr_o      ROM read strobe/address, one fetch per cycle
//   rom_data_i                ROM data, ROM_LATENCY cycles after its strobe
//   hit_cnt_o, redirect_cnt_o saturating acknowledge/redirect counters,
//                             present only when FETCH_STATS_EN is defined
//   dbg_state                 current FSM state
// Handshake: the core raises req_i with addr_i and holds both unchanged until
// the cycle where inst_valid_o=1; in that cycle request and inst_o are
// consumed, and the core may present its next request in the following cycle.
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter int ADDR_W      = InstAddrBus,
  parameter int DATA_W      = InstBus,
  parameter int ROM_LATENCY = 2,
  parameter int BUF_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
`ifdef FETCH_STATS_EN
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       redirect_cnt_o,
`endif
  output fetch_state_t      dbg_state
);

  localparam int INC   = DATA_W / 8;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int SUM_W = $clog2(BUF_DEPTH + ROM_LATENCY + 1) + 1;
  localparam logic [ADDR_W-1:0] INC_A    = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INC - 1);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_ptr;
  logic [ADDR_W-1:0] addr_a;

  // In-flight ROM reads: stage i holds the read issued i+1 cycles ago.
  logic [ROM_LATENCY-1:0] stage_v;
  logic [ADDR_W-1:0]      stage_tag [ROM_LATENCY];

  logic [ADDR_W-1:0] head_tag;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  occ;
  logic              buf_empty;

  logic [SUM_W-1:0]  infl_cnt;
  logic              streaming, hit, miss, space, issue;

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      infl_cnt = infl_cnt + SUM_W'(stage_v[i]);
    end
  end

  assign addr_a    = addr_i & ~LOW_MASK;
  assign streaming = (state == STREAM);
  assign hit       = streaming && req_i && !buf_empty && (head_tag == addr_a);
  // With an empty buffer but reads still in flight we cannot yet tell whether
  // the stream matches, so we wait for the data instead of redirecting.
  assign miss      = streaming && req_i &&
                     (buf_empty ? ((infl_cnt == '0) && (fetch_ptr != addr_a))
                                : (head_tag != addr_a));
  // A pop in this cycle frees a slot; a returning read only moves from the
  // in-flight count into occupancy, so it does not change the total.
  assign space     = (SUM_W'(occ) + infl_cnt - SUM_W'(hit)) < SUM_W'(BUF_DEPTH);
  assign issue     = streaming && !miss && space;

  assign inst_valid_o = hit;
  assign inst_o       = hit ? head_data : '0;
  assign rom_ce_o     = issue;
  assign rom_addr_o   = issue ? fetch_ptr : '0;
  assign dbg_state    = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            fetch_ptr <= addr_a;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (miss)       fetch_ptr <= addr_a;
          else if (issue) fetch_ptr <= fetch_ptr + INC_A;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_v <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) stage_tag[i] <= '0;
    end else begin
      stage_tag[0] <= fetch_ptr;
      for (int i = 1; i < ROM_LATENCY; i++) stage_tag[i] <= stage_tag[i-1];
      if (miss) begin
        stage_v <= '0;
      end else begin
        stage_v[0] <= issue;
        for (int i = 1; i < ROM_LATENCY; i++) stage_v[i] <= stage_v[i-1];
      end
    end
  end

  // A redirect clears the buffer, which also discards any data returning now.
  fetch_buf #(
    .TAG_W (ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clear    (miss),
    .push     (stage_v[ROM_LATENCY-1]),
    .push_tag (stage_tag[ROM_LATENCY-1]),
    .push_data(rom_data_i),
    .pop      (hit),
    .head_tag (head_tag),
    .head_data(head_data),
    .count    (occ),
    .empty    (buf_empty)
  );

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_o      <= '0;
      redirect_cnt_o <= '0;
    end else begin
      if (hit && (hit_cnt_o != '1))       hit_cnt_o      <= hit_cnt_o + 32'd1;
      if (miss && (redirect_cnt_o != '1)) redirect_cnt_o <= redirect_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Testbench for inst_fetch_bridge: directed scenarios with literal
// expectations plus a randomized program-flow phase, all checked every cycle
// against a queue-based behavioural model of the fetch bridge.
module tb_inst_fetch_bridge;
  import inst_fetch_bridge_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int INC   = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] inst, rom_addr, rom_data;
  logic        inst_valid, rom_ce;
  fetch_state_t dbg_state;
`ifdef FETCH_STATS_EN
  logic [31:0] hit_cnt, redirect_cnt;
`endif

  always #5 clk = ~clk;

  inst_fetch_bridge #(
    .ADDR_W(32), .DATA_W(32), .ROM_LATENCY(LAT), .BUF_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .addr_i      (addr),
    .inst_o      (inst),
    .inst_valid_o(inst_valid),
    .rom_ce_o    (rom_ce),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
`ifdef FETCH_STATS_EN
    .hit_cnt_o     (hit_cnt),
    .redirect_cnt_o(redirect_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- ROM with fixed read latency ----------------
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return a >> 2;
  endfunction

  logic           cap_v = 1'b0;
  logic [31:0]    cap_a = '0;
  logic [LAT-1:0] pv = '0;
  logic [31:0]    pa [LAT] = '{default: 32'h0};

  always @(negedge clk) begin
    cap_v = rom_ce;
    cap_a = rom_addr;
  end

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
    pv[0] <= cap_v;
    pa[0] <= cap_a;
  end

  assign rom_data = pv[LAT-1] ? rom_fn(pa[LAT-1]) : 32'hDEAD_BEEF;

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buffer and in-flight reads are plain queues; a read issued in cycle c
  // lands in the buffer at the end of cycle c+LAT.
  typedef struct { logic [31:0] tag; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] tag; int due; } fl_t;

  ent_t        m_buf[$];
  fl_t         m_fl[$];
  logic        m_started = 1'b0;
  logic [31:0] m_ptr = '0;
  int          cyc = 0;
  logic [31:0] ce_log[$];
  int          ce_count  = 0;
  int          ack_count = 0;

  initial begin
    logic        d_valid, d_req, d_hit, d_miss, d_issue;
    logic [31:0] d_a, exp_inst;
    forever begin
      @(negedge clk);
      d_valid = 1'b0;
      d_req = 1'b0; d_hit = 1'b0; d_miss = 1'b0; d_issue = 1'b0;
      d_a = '0;
      if (rom_ce) begin
        ce_log.push_back(rom_addr);
        ce_count++;
      end
      if (inst_valid) ack_count++;
      if (!rst) begin
        m_buf.delete();
        m_fl.delete();
        m_started = 1'b0;
        m_ptr = '0;
        check("rst_ack", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_rom_ce", 32'(rom_ce), 32'd0);
        check("rst_rom_addr", rom_addr, 32'd0);
      end else begin
        d_req = req;
        d_a = addr & ~32'h3;
        if (m_started && req) begin
          if (m_buf.size() > 0) begin
            d_hit  = (m_buf[0].tag == d_a);
            d_miss = !d_hit;
          end else begin
            d_miss = (m_fl.size() == 0) && (m_ptr != d_a);
          end
        end
        if (m_started && !d_miss)
          d_issue = (m_buf.size() + m_fl.size() - int'(d_hit)) < DEPTH;
        exp_inst = d_hit ? m_buf[0].data : 32'd0;
        check("ack", 32'(inst_valid), 32'(d_hit));
        check("inst", inst, exp_inst);
        check("rom_ce", 32'(rom_ce), 32'(d_issue));
        check("rom_addr", rom_addr, d_issue ? m_ptr : 32'd0);
        d_valid = 1'b1;
      end
      @(posedge clk);
      if (d_valid && rst) begin
        if (!m_started) begin
          if (d_req) begin
            m_started = 1'b1;
            m_ptr = d_a;
          end
        end else if (d_miss) begin
          m_buf.delete();
          m_fl.delete();
          m_ptr = d_a;
        end else begin
          if (d_hit) void'(m_buf.pop_front());
          while (m_fl.size() > 0 && m_fl[0].due == cyc) begin
            ent_t e;
            e.tag  = m_fl[0].tag;
            e.data = rom_fn(m_fl[0].tag);
            m_buf.push_back(e);
            void'(m_fl.pop_front());
          end
          if (d_issue) begin
            fl_t f;
            f.tag = m_ptr;
            f.due = cyc + LAT;
            m_fl.push_back(f);
            m_ptr = m_ptr + INC;
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    req = 1'b0;
    repeat (k) tick();
  endtask

  task automatic do_reset();
    req  = 1'b0;
    addr = '0;
    rst  = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  // Present a request and hold it until acknowledged. lat counts the cycles
  // before the acknowledge cycle. Returns just after the next rising edge.
  task automatic fetch(input logic [31:0] a, output int lat, output logic [31:0] data);
    req  = 1'b1;
    addr = a;
    lat  = 0;
    data = '0;
    forever begin
      @(negedge clk);
      if (inst_valid) begin
        data = inst;
        break;
      end
      lat++;
      if (lat > 60) begin
        n_cmp++;
        n_fail++;
        $display("FAIL fetch_timeout addr 0x%08h: no ack after %0d cycles, ack required", a, lat);
        req = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat, c0, a0, r;
    logic [31:0] d, pc, a;
    logic [31:0] wrap_exp [4];
    wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    // Power-on asynchronous reset.
    #1 rst = 1'b0;
    #1;
    check("por_ack", 32'(inst_valid), 32'd0);
    check("por_rom_ce", 32'(rom_ce), 32'd0);
    check("por_state", 32'(dbg_state), 32'(IDLE));
    repeat (3) tick();
    rst = 1'b1;

    // Cold start: 0x0, 0x4, 0x8, 0xC with req held.
    fetch(32'h0, lat, d);
    check("cold_lat", lat, 32'd4);
    check("cold_data", d, 32'd0);
    for (int k = 1; k < 4; k++) begin
      fetch(32'(k * 4), lat, d);
      check("seq_lat", lat, 32'd0);
      check("seq_data", d, 32'(k));
    end

    // Branch after the 0x4 acknowledge; stale 0x8/0xC must not surface.
    do_reset();
    fetch(32'h0, lat, d);
    fetch(32'h4, lat, d);
    check("pre_branch_data", d, 32'd1);
    fetch(32'h100, lat, d);
    check("branch_lat", lat, 32'(LAT + 2));
    check("branch_data", d, 32'h40);
`ifdef FETCH_STATS_EN
    check("hit_cnt", hit_cnt, 32'd3);
    check("redirect_cnt", redirect_cnt, 32'd1);
`endif
    fetch(32'h104, lat, d);
    check("post_branch_data", d, 32'h41);

    // Backpressure: the buffer fills to DEPTH and fetching stalls.
    do_reset();
    c0 = ce_count;
    fetch(32'h200, lat, d);
    check("bp_first_data", d, 32'h80);
    idle(10);
    check("bp_fetches", 32'(ce_count - c0), 32'(DEPTH + 1));
    check("bp_stalled", 32'(rom_ce), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      fetch(32'h200 + 32'(4 * k), lat, d);
      check("bp_resume_lat", lat, 32'd0);
      check("bp_resume_data", d, 32'h80 + 32'(k));
    end

    // Address wrap.
    do_reset();
    ce_log.delete();
    fetch(32'hFFFF_FFF8, lat, d);
    check("wrap_data0", d, 32'h3FFF_FFFE);
    fetch(32'hFFFF_FFFC, lat, d);
    check("wrap_data1", d, 32'h3FFF_FFFF);
    fetch(32'h0000_0000, lat, d);
    check("wrap_data2", d, 32'h0);
    fetch(32'h0000_0004, lat, d);
    check("wrap_data3", d, 32'h1);
    for (int k = 0; k < 4; k++)
      check("wrap_rom_addr", (k < ce_log.size()) ? ce_log[k] : 32'hBAD0_0000, wrap_exp[k]);

    // Asynchronous reset mid-stream, between clock edges.
    do_reset();
    fetch(32'h300, lat, d);
    req  = 1'b1;
    addr = 32'h304;
    #1;
    check("pre_rst_ack", 32'(inst_valid), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_ack", 32'(inst_valid), 32'd0);
    check("mid_rst_inst", inst, 32'd0);
    check("mid_rst_rom_ce", 32'(rom_ce), 32'd0);
    check("mid_rst_rom_addr", rom_addr, 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1;
    req = 1'b0;
    rst = 1'b1;
    c0 = ce_count;
    a0 = ack_count;
    idle(5);
    check("post_rst_no_fetch", 32'(ce_count - c0), 32'd0);
    check("post_rst_no_ack", 32'(ack_count - a0), 32'd0);
    fetch(32'h300, lat, d);
    check("post_rst_lat", lat, 32'd4);
    check("post_rst_data", d, 32'hC0);

    // Randomized program flow: sequential runs, branches, wrap, idle gaps.
    do_reset();
    pc = $urandom & ~32'h3;
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      pc = $urandom & ~32'h3;
      else if (r < 16) pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else if (r < 20) pc = pc - 32'd8;
      else if (t > 0)  pc = pc + 32'd4;
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 12));
      a = pc | 32'($urandom_range(0, 3));
      fetch(a, lat, d);
      check("rand_data", d, rom_fn(pc));
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, finish required");
    $fatal(1, "watchdog expired");
  end

endmodule
